alu_nibble_seq: RTL and testbench
=================================

Name: alu_nibble_seq

Overview:
Multi-cycle sequencer that computes NIBBLES*4-bit ALU operations using one shared, purely combinational 4-bit ALU slice, one nibble per clock. It latches a wide operation request, steers operand nibbles and the inter-nibble carry to the slice, and collects the result nibbles. It also accumulates word-level carry, zero and equality status. It sits between the register file/requester and the slice instance; the slice is instantiated beside it at the same level.

Parameters:
NIBBLES, 4, number of 4-bit nibbles per word (word width W = 4*NIBBLES); legal range 2..16.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request pulse; sampled only in IDLE
op  in  3  function code: 0 ADD, 1 AND, 2 OR, 3 XOR, 4 PASSA, 5 PASSB, 6 SHR, 7 SHL
com  in  1  ones-complement-output mode for the whole word
cin  in  1  carry-in (ADD), shift-in bit (SHL/SHR)
a  in  W  operand A
b  in  W  operand B
busy  out  1  high in RUN and DONE; requester holds start until busy low
done  out  1  one-cycle pulse; result/status valid from this cycle
result  out  W  word result, held until next accepted start
cout  out  1  ADD carry out / SHL MSB out / SHR LSB out; 0 for ops 1-5
zero  out  1  result == 0 (after com)
equ  out  1  a == b
alu_f  out  3  slice function code
alu_com  out  1  slice COM
alu_da  out  4  slice port A nibble
alu_db  out  4  slice port B nibble
alu_ci_right  out  1  slice right carry in
alu_ci_left  out  1  slice left carry in
alu_d  in  4  slice result nibble
alu_co_left  in  1  slice left carry out
alu_co_right  in  1  slice right carry out
alu_equ  in  1  slice nibble-equal flag

Behaviour:
- Reset (async, rst_n low): state IDLE; result 0, cout 0, zero 0, equ 0, busy 0, done 0. All alu_* outputs 0. Operand/carry registers cleared. Reset mid-RUN aborts the operation; no done is produced.
- States: IDLE -> RUN on start; RUN -> DONE after the last nibble; DONE -> IDLE unconditionally after 1 cycle.
- IDLE, start=1:
  - latch a, b, op, com.
  - carry_reg <= cin; zero_acc <= 1; equ_acc <= 1.
  - idx <= 0 for op != 6; idx <= NIBBLES-1 for SHR.
- Start ignored in RUN/DONE (no queueing).
- RUN, one nibble per cycle, combinational drive:
  - alu_f=op_reg, alu_com=com_reg, alu_da=a_reg[idx], alu_db=b_reg[idx].
  - op != 6: alu_ci_right=carry_reg, alu_ci_left=0.
  - op == 6: alu_ci_left=carry_reg, alu_ci_right=0.
- RUN, registered same edge:
  - result nibble idx <= alu_d.
  - zero_acc <= zero_acc & (alu_d==0).
  - equ_acc <= equ_acc & alu_equ.
  - carry_reg <= alu_co_right for SHR, else alu_co_left.
  - idx increments (LSB-first) or decrements (SHR, MSB-first).
- Leave RUN when the processed idx was NIBBLES-1 (LSB-first) or 0 (SHR).
- Output status:
  - On entry to DONE: cout <= final carry_reg value, except ops 1-5 force cout 0. zero <= zero_acc, equ <= equ_acc.
  - result/zero/equ/cout stay stable from DONE until the next accepted start; they are not cleared in IDLE.
- Latency: start sampled at edge 0; RUN occupies cycles 1..NIBBLES; done=1 in cycle NIBBLES+1; start next accepted in cycle NIBBLES+2.
- Outside RUN, all alu_* outputs are driven 0.
- com affects data only; carry chain is unaffected (slice behaviour).

Decomposition:
- Shared package alu_seq_pkg:
  - op code constants OP_ADD..OP_SHL (0..7).
  - state encoding IDLE/RUN/DONE.
  - nibble width constant 4.
- No sub-module: nibble mux/demux is inline. The 4-bit slice is a sibling instance wired to the alu_* ports; the bench instantiates both.

Test Plan:
- NIBBLES=4, ADD a=0x1234 b=0x0FFF cin=0 -> result 0x2233, cout 0, zero 0, done exactly 5 cycles after start edge; busy high cycles 1..5.
- ADD a=0xFFFF b=0x0001 cin=0 -> result 0x0000, cout 1, zero 1; then a=b=0xBEEF -> equ 1, result 0x7DDE, cout 1.
- SHL a=0x8421 cin=1 -> 0x0843, cout 1; SHR a=0x8421 cin=1 -> 0xC210, cout 1, nibbles processed 3,2,1,0 (check alu_da order).
- XOR a=0x00FF b=0x0F0F com=1 -> result 0xF00F, cout 0, equ 0; PASSB b=0x0000 com=1 -> 0xFFFF, zero 0.
- start pulsed during RUN with different operands -> ignored, first result unchanged, single done pulse.
- rst_n low in cycle 2 of RUN -> all outputs 0 immediately, no done; next start runs a fresh ADD correctly.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the nibble-serial ALU sequencer: op codes,
// FSM state encoding and nibble width.
package alu_seq_pkg;

   localparam int NIB_W = 4;

   localparam logic [2:0] OP_ADD   = 3'd0;
   localparam logic [2:0] OP_AND   = 3'd1;
   localparam logic [2:0] OP_OR    = 3'd2;
   localparam logic [2:0] OP_XOR   = 3'd3;
   localparam logic [2:0] OP_PASSA = 3'd4;
   localparam logic [2:0] OP_PASSB = 3'd5;
   localparam logic [2:0] OP_SHR   = 3'd6;
   localparam logic [2:0] OP_SHL   = 3'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Logic and pass ops carry no meaningful word carry
   function automatic logic op_forces_zero_cout(input logic [2:0] op);
      return (op >= OP_AND) && (op <= OP_PASSB);
   endfunction

endpackage

// File: rtl/alu_nibble_seq_if.sv
// Requester-side bus of the nibble-serial ALU sequencer.
interface alu_nibble_seq_if
   import alu_seq_pkg::*;
#(
   parameter int NIBBLES = 4
);
   logic                     start;
   logic [2:0]               op;
   logic                     com;
   logic                     cin;
   logic [NIB_W*NIBBLES-1:0] a;
   logic [NIB_W*NIBBLES-1:0] b;
   logic                     busy;
   logic                     done;
   logic [NIB_W*NIBBLES-1:0] result;
   logic                     cout;
   logic                     zero;
   logic                     equ;

   modport master (
      output start, op, com, cin, a, b,
      input  busy, done, result, cout, zero, equ
   );

   modport slave (
      input  start, op, com, cin, a, b,
      output busy, done, result, cout, zero, equ
   );
endinterface

// File: rtl/alu_nibble_seq_slice.sv
// Purely combinational 4-bit ALU slice shared by the sequencer; com inverts
// the data output only, never the carries.
module alu_nibble_seq_slice
   import alu_seq_pkg::*;
(
   input  logic [2:0] f,
   input  logic       com,
   input  logic [3:0] da,
   input  logic [3:0] db,
   input  logic       ci_right,
   input  logic       ci_left,
   output logic [3:0] d,
   output logic       co_left,
   output logic       co_right,
   output logic       equ
);
   logic [3:0] raw_s;

   // Nibble function, carries and equality
   always_comb begin
      raw_s    = 4'd0;
      co_left  = 1'b0;
      co_right = 1'b0;
      case (f)
         OP_ADD:   {co_left, raw_s} = {1'b0, da} + {1'b0, db} + {4'd0, ci_right};
         OP_AND:   raw_s = da & db;
         OP_OR:    raw_s = da | db;
         OP_XOR:   raw_s = da ^ db;
         OP_PASSA: raw_s = da;
         OP_PASSB: raw_s = db;
         OP_SHR: begin
            raw_s    = {ci_left, da[3:1]};
            co_right = da[0];
         end
         OP_SHL: begin
            raw_s   = {da[2:0], ci_right};
            co_left = da[3];
         end
         default:  raw_s = 4'd0;
      endcase
      d   = raw_s ^ {4{com}};
      equ = (da == db);
   end
endmodule

// File: rtl/alu_nibble_seq.sv
// Multi-cycle sequencer: runs a wide ALU operation one nibble per clock through
// an external 4-bit slice and accumulates word-level carry/zero/equality status.
module alu_nibble_seq
   import alu_seq_pkg::*;
#(
   parameter int NIBBLES = 4
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   alu_nibble_seq_if.slave       bus,
   output logic [2:0]            alu_f,
   output logic                  alu_com,
   output logic [3:0]            alu_da,
   output logic [3:0]            alu_db,
   output logic                  alu_ci_right,
   output logic                  alu_ci_left,
   input  logic [3:0]            alu_d,
   input  logic                  alu_co_left,
   input  logic                  alu_co_right,
   input  logic                  alu_equ
);
   localparam int W     = NIB_W * NIBBLES;
   localparam int IDX_W = $clog2(NIBBLES);

   state_t             state_r;
   state_t             next_state_s;
   logic [W-1:0]       a_r;
   logic [W-1:0]       b_r;
   logic [2:0]         op_r;
   logic               com_r;
   logic               carry_r;
   logic               zero_acc_r;
   logic               equ_acc_r;
   logic [IDX_W-1:0]   idx_r;
   logic [W-1:0]       result_r;
   logic               cout_r;
   logic               zero_r;
   logic               equ_r;
   logic               busy_r;
   logic               done_r;
   logic [IDX_W+1:0]   nib_base_s;
   logic               last_s;
   logic               carry_next_s;

   assign nib_base_s   = {idx_r, 2'b00};
   assign last_s       = (op_r == OP_SHR) ? (idx_r == {IDX_W{1'b0}})
                                          : (idx_r == IDX_W'(NIBBLES - 1));
   assign carry_next_s = (op_r == OP_SHR) ? alu_co_right : alu_co_left;

   // Next-state decode and slice steering (slice sees zeros outside RUN)
   always_comb begin
      next_state_s = state_r;
      alu_f        = 3'd0;
      alu_com      = 1'b0;
      alu_da       = 4'd0;
      alu_db       = 4'd0;
      alu_ci_right = 1'b0;
      alu_ci_left  = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.start) next_state_s = RUN;
            else           next_state_s = IDLE;
         end
         RUN: begin
            alu_f   = op_r;
            alu_com = com_r;
            alu_da  = a_r[nib_base_s +: NIB_W];
            alu_db  = b_r[nib_base_s +: NIB_W];
            if (op_r == OP_SHR) alu_ci_left  = carry_r;
            else                alu_ci_right = carry_r;
            if (last_s) next_state_s = DONE;
            else        next_state_s = RUN;
         end
         DONE:    next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= IDLE;
      else        state_r <= next_state_s;
   end

   // Operand latch, nibble collection and word status
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r        <= {W{1'b0}};
         b_r        <= {W{1'b0}};
         op_r       <= 3'd0;
         com_r      <= 1'b0;
         carry_r    <= 1'b0;
         zero_acc_r <= 1'b0;
         equ_acc_r  <= 1'b0;
         idx_r      <= {IDX_W{1'b0}};
         result_r   <= {W{1'b0}};
         cout_r     <= 1'b0;
         zero_r     <= 1'b0;
         equ_r      <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         busy_r <= (next_state_s != IDLE);
         done_r <= (next_state_s == DONE);
         case (state_r)
            IDLE: begin
               if (bus.start) begin
                  a_r        <= bus.a;
                  b_r        <= bus.b;
                  op_r       <= bus.op;
                  com_r      <= bus.com;
                  carry_r    <= bus.cin;
                  zero_acc_r <= 1'b1;
                  equ_acc_r  <= 1'b1;
                  idx_r      <= (bus.op == OP_SHR) ? IDX_W'(NIBBLES - 1) : {IDX_W{1'b0}};
               end
            end
            RUN: begin
               result_r[nib_base_s +: NIB_W] <= alu_d;
               zero_acc_r <= zero_acc_r & (alu_d == 4'd0);
               equ_acc_r  <= equ_acc_r & alu_equ;
               carry_r    <= carry_next_s;
               if (op_r == OP_SHR) idx_r <= idx_r - IDX_W'(1);
               else                idx_r <= idx_r + IDX_W'(1);
               // Publish status on the edge that enters DONE
               if (last_s) begin
                  cout_r <= op_forces_zero_cout(op_r) ? 1'b0 : carry_next_s;
                  zero_r <= zero_acc_r & (alu_d == 4'd0);
                  equ_r  <= equ_acc_r & alu_equ;
               end
            end
            DONE: begin
               carry_r <= carry_r;
            end
            default: begin
               carry_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy   = busy_r;
   assign bus.done   = done_r;
   assign bus.result = result_r;
   assign bus.cout   = cout_r;
   assign bus.zero   = zero_r;
   assign bus.equ    = equ_r;
endmodule

// File: tb/tb_alu_nibble_seq.sv
// Directed scoreboard bench for alu_nibble_seq (NIBBLES=4) with its slice.
module tb_alu_nibble_seq;
   localparam int N = 4;

   typedef struct {
      logic [15:0] res;
      logic        co;
      logic        z;
      logic        e;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [2:0]  alu_f;
   logic        alu_com;
   logic [3:0]  alu_da;
   logic [3:0]  alu_db;
   logic        alu_ci_right;
   logic        alu_ci_left;
   logic [3:0]  alu_d;
   logic        alu_co_left;
   logic        alu_co_right;
   logic        alu_equ;

   int          total;
   int          passes;
   int          fails;
   int          done_cnt;
   int          pushes;
   exp_t        sb_q[$];

   int          dk;
   int          nd;
   logic [7:0]  bz;
   logic [15:0] das;

   alu_nibble_seq_if #(.NIBBLES(N)) bus ();

   alu_nibble_seq #(.NIBBLES(N)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .alu_f(alu_f), .alu_com(alu_com), .alu_da(alu_da), .alu_db(alu_db),
      .alu_ci_right(alu_ci_right), .alu_ci_left(alu_ci_left),
      .alu_d(alu_d), .alu_co_left(alu_co_left), .alu_co_right(alu_co_right),
      .alu_equ(alu_equ)
   );

   alu_nibble_seq_slice slice (
      .f(alu_f), .com(alu_com), .da(alu_da), .db(alu_db),
      .ci_right(alu_ci_right), .ci_left(alu_ci_left),
      .d(alu_d), .co_left(alu_co_left), .co_right(alu_co_right), .equ(alu_equ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Word-level reference of the whole operation
   function automatic exp_t model(input logic [2:0] op, input logic c, input logic ci,
                                  input logic [15:0] a, input logic [15:0] b);
      exp_t        e;
      logic [16:0] t;
      case (op)
         3'd0:    t = {1'b0, a} + {1'b0, b} + {16'd0, ci};
         3'd1:    t = {1'b0, a & b};
         3'd2:    t = {1'b0, a | b};
         3'd3:    t = {1'b0, a ^ b};
         3'd4:    t = {1'b0, a};
         3'd5:    t = {1'b0, b};
         3'd6:    t = {a[0], ci, a[15:1]};
         3'd7:    t = {a, ci};
         default: t = 17'd0;
      endcase
      e.res = t[15:0] ^ {16{c}};
      e.co  = t[16];
      e.z   = (e.res == 16'd0);
      e.e   = (a == b);
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) passes = passes + 1;
      else begin
         fails = fails + 1;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_start(input logic [2:0] op, input logic c, input logic ci,
                              input logic [15:0] a, input logic [15:0] b, input bit push);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = op;
      bus.com   = c;
      bus.cin   = ci;
      bus.a     = a;
      bus.b     = b;
      @(posedge clk);
      if (push) begin
         sb_q.push_back(model(op, c, ci, a, b));
         pushes = pushes + 1;
      end
      #1;
      bus.start = 1'b0;
   endtask

   task automatic run_op(input logic [2:0] op, input logic c, input logic ci,
                         input logic [15:0] a, input logic [15:0] b,
                         output int dk_o, output int nd_o,
                         output logic [7:0] bz_o, output logic [15:0] das_o);
      drive_start(op, c, ci, a, b, 1'b1);
      dk_o  = -1;
      nd_o  = 0;
      bz_o  = 8'd0;
      das_o = 16'd0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         bz_o[k-1] = bus.busy;
         if (bus.done) begin
            nd_o = nd_o + 1;
            if (dk_o < 0) dk_o = k;
         end
         if (k <= N) das_o = {das_o[11:0], alu_da};
      end
   endtask

   // Scoreboard: every done pops one expected result
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus.done) begin
         done_cnt = done_cnt + 1;
         check("sb_pending", 32'(sb_q.size() > 0), 32'd1);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("result", 32'(bus.result), 32'(e.res));
            check("cout", 32'(bus.cout), 32'(e.co));
            check("zero", 32'(bus.zero), 32'(e.z));
            check("equ", 32'(bus.equ), 32'(e.e));
         end
      end
   end

   initial begin
      total = 0; passes = 0; fails = 0; done_cnt = 0; pushes = 0;
      rst_n = 1'b0;
      bus.start = 1'b0; bus.op = 3'd0; bus.com = 1'b0; bus.cin = 1'b0;
      bus.a = 16'd0; bus.b = 16'd0;
      repeat (3) @(negedge clk);
      check("rst_status", 32'({bus.busy, bus.done, bus.cout, bus.zero, bus.equ}), 32'd0);
      check("rst_result", 32'(bus.result), 32'd0);
      check("rst_alu", 32'({alu_f, alu_com, alu_da, alu_db, alu_ci_right, alu_ci_left}), 32'd0);
      rst_n = 1'b1;

      run_op(3'd0, 1'b0, 1'b0, 16'h1234, 16'h0FFF, dk, nd, bz, das);
      check("add_latency", 32'(dk), 32'(N + 1));
      check("add_single_done", 32'(nd), 32'd1);
      check("add_busy", 32'(bz), 32'h1F);
      check("add_nibble_order", 32'(das), 32'h4321);

      run_op(3'd0, 1'b0, 1'b0, 16'hFFFF, 16'h0001, dk, nd, bz, das);
      run_op(3'd0, 1'b0, 1'b0, 16'hBEEF, 16'hBEEF, dk, nd, bz, das);
      check("hold_result", 32'(bus.result), 32'h7DDE);

      run_op(3'd7, 1'b0, 1'b1, 16'h8421, 16'h0000, dk, nd, bz, das);
      run_op(3'd6, 1'b0, 1'b1, 16'h8421, 16'h0000, dk, nd, bz, das);
      check("shr_latency", 32'(dk), 32'(N + 1));
      check("shr_nibble_order", 32'(das), 32'h8421);

      run_op(3'd3, 1'b1, 1'b0, 16'h00FF, 16'h0F0F, dk, nd, bz, das);
      run_op(3'd5, 1'b1, 1'b0, 16'h1234, 16'h0000, dk, nd, bz, das);

      for (int i = 0; i < 8; i++) begin
         run_op(3'($urandom_range(7, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                16'($urandom), 16'($urandom), dk, nd, bz, das);
         check("rand_single_done", 32'(nd), 32'd1);
      end

      // Start re-pulsed mid-RUN with other operands must be ignored
      drive_start(3'd0, 1'b0, 1'b0, 16'h1111, 16'h2222, 1'b1);
      nd = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (bus.done) nd = nd + 1;
         if (k == 2) begin
            bus.start = 1'b1; bus.op = 3'd2; bus.a = 16'hAAAA; bus.b = 16'h5555;
         end
         if (k == 4) bus.start = 1'b0;
      end
      check("ignored_start_done", 32'(nd), 32'd1);
      check("ignored_start_idle", 32'(bus.busy), 32'd0);

      // Reset in the second RUN cycle aborts without a done
      drive_start(3'd0, 1'b0, 1'b0, 16'h5555, 16'h1111, 1'b0);
      @(negedge clk);
      @(negedge clk);
      check("pre_abort_busy", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort_status", 32'({bus.busy, bus.done, bus.cout, bus.zero, bus.equ}), 32'd0);
      check("abort_result", 32'(bus.result), 32'd0);
      check("abort_alu", 32'({alu_f, alu_com, alu_da, alu_db, alu_ci_right, alu_ci_left}), 32'd0);
      nd = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (bus.done) nd = nd + 1;
      end
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (bus.done) nd = nd + 1;
      end
      check("abort_no_done", 32'(nd), 32'd0);

      run_op(3'd0, 1'b0, 1'b1, 16'h0F0F, 16'h00F1, dk, nd, bz, das);
      check("post_abort_latency", 32'(dk), 32'(N + 1));

      check("sb_drained", 32'(sb_q.size()), 32'd0);
      check("done_count", 32'(done_cnt), 32'(pushes));

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule
